// File: rtl/bip_pkg.sv
// ---------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP data-memory path: owner tags for the memory
// read pipeline, the arbiter state encoding and a ceil(log2) helper used to
// size counters and memory address buses.
// ---------------------------------------------------------------------------
package bip_pkg;

    // Who issued the access in a given cycle; also used as the read-return tag.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // ARB: normal priority arbitration. STEAL: one forced debug slot.
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_STEAL = 1'b1
    } arb_state_e;

    // Smallest w such that 2**w >= value (returns 0 for value <= 1).
    function automatic int clogb2(input int value);
        int w;
        w = 0;
        while ((64'(1) << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bip_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// bip_dmem_arbiter
// Shares the single BIP data memory between the CPU data port and a debug
// requester. The CPU wins by default; a debug request that has lost MAX_WAIT
// contended cycles forces a one-cycle CPU stall and takes that slot.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cpu_*             CPU data port (addr, write data, wr/rd strobes)
//   o_cpu_data          read data returned to the CPU (held between reads)
//   o_cpu_stall         registered; CPU repeats its access next cycle
//   i_dbg_*             debug request (held until o_dbg_gnt)
//   o_dbg_gnt           one-cycle pulse, request consumed this cycle
//   o_dbg_rvalid/rdata  debug read return, two cycles after the grant
//   o_mem_*, i_mem_data data-memory port (read data one cycle after o_mem_rd)
// ---------------------------------------------------------------------------
module bip_dmem_arbiter
    import bip_pkg::*;
#(
    parameter int NB_BITS  = 16,
    parameter int NB_ADDR  = 11,
    parameter int MAX_WAIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_ADDR-1:0] i_cpu_addr,
    input  logic [NB_BITS-1:0] i_cpu_data,
    input  logic               i_cpu_wr,
    input  logic               i_cpu_rd,
    output logic [NB_BITS-1:0] o_cpu_data,
    output logic               o_cpu_stall,
    input  logic               i_dbg_req,
    input  logic               i_dbg_we,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [NB_BITS-1:0] i_dbg_data,
    output logic               o_dbg_gnt,
    output logic               o_dbg_rvalid,
    output logic [NB_BITS-1:0] o_dbg_rdata,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_BITS-1:0] o_mem_data,
    output logic               o_mem_wr,
    output logic               o_mem_rd,
    input  logic [NB_BITS-1:0] i_mem_data
);

    localparam int NB_CNT_RAW = clogb2(MAX_WAIT + 1);
    localparam int NB_CNT     = (NB_CNT_RAW < 1) ? 1 : NB_CNT_RAW;
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(MAX_WAIT);

    arb_state_e         state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               stall_q, stall_d;
    owner_e             rd_tag_q, rd_tag_d;
    logic               dbg_rvalid_q;
    logic [NB_BITS-1:0] dbg_rdata_q;
    logic [NB_BITS-1:0] cpu_hold_q;

    owner_e             owner;
    logic               dbg_gnt;
    logic               cpu_acc;
    logic               mem_wr;
    logic               mem_rd;

    assign cpu_acc = i_cpu_wr | i_cpu_rd;

    // Owner selection and next state.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned -- otherwise synthesis would infer a latch.
    always_comb begin
        owner   = OWN_NONE;
        dbg_gnt = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;

        // While reset is held nobody owns the memory, so a pending debug
        // request is not consumed and is re-arbitrated after release.
        if (!i_rst) begin
            case (state_q)
                ST_STEAL: begin
                    owner   = OWN_DBG;
                    dbg_gnt = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ARB;
                end
                default: begin
                    if (!i_dbg_req) begin
                        owner = OWN_CPU;
                        cnt_d = '0;
                    end else if (!cpu_acc) begin
                        owner   = OWN_DBG;
                        dbg_gnt = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        owner = OWN_CPU;
                        if (cnt_q == CNT_MAX) begin
                            // CPU keeps this cycle; the stolen slot is next.
                            cnt_d   = '0;
                            stall_d = 1'b1;
                            state_d = ST_STEAL;
                        end else begin
                            cnt_d = cnt_q + NB_CNT'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Combinational memory mux; CPU strobes are dropped whenever DBG owns.
    always_comb begin
        o_mem_addr = i_cpu_addr;
        o_mem_data = i_cpu_data;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        case (owner)
            OWN_DBG: begin
                o_mem_addr = i_dbg_addr;
                o_mem_data = i_dbg_data;
                mem_wr     = i_dbg_we;
                mem_rd     = ~i_dbg_we;
            end
            OWN_CPU: begin
                mem_wr = i_cpu_wr;
                mem_rd = i_cpu_rd;
            end
            default: ;
        endcase
        rd_tag_d = mem_rd ? owner : OWN_NONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_ARB;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            rd_tag_q     <= OWN_NONE;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            cpu_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            rd_tag_q     <= rd_tag_d;
            dbg_rvalid_q <= (rd_tag_q == OWN_DBG);
            if (rd_tag_q == OWN_DBG) begin
                dbg_rdata_q <= i_mem_data;
            end
            if (rd_tag_q == OWN_CPU) begin
                cpu_hold_q <= i_mem_data;
            end
        end
    end

    // CPU sees memory data directly in the return cycle, the held copy
    // otherwise, so a debug read never disturbs CPU-visible data.
    assign o_cpu_data   = (rd_tag_q == OWN_CPU) ? i_mem_data : cpu_hold_q;
    assign o_cpu_stall  = stall_q;
    assign o_dbg_gnt    = dbg_gnt;
    assign o_dbg_rvalid = dbg_rvalid_q;
    assign o_dbg_rdata  = dbg_rdata_q;
    assign o_mem_wr     = mem_wr;
    assign o_mem_rd     = mem_rd;

endmodule
